// File: rtl/camera_pkg.sv
// Shared types and constants for the DVP camera capture front end.
package camera_pkg;

  // Framing FSM states
  typedef enum logic [1:0] {
    WAIT_VS   = 2'd0,
    WAIT_FALL = 2'd1,
    ACTIVE    = 2'd2,
    DONE      = 2'd3
  } cap_state_e;

  localparam int unsigned SLOT_COUNT     = 6;
  localparam int unsigned BYTES_PER_WORD = 16;

  // Number of 128-bit words in one RGB565 frame (2 bytes per pixel)
  function automatic int unsigned words_per_frame(input int unsigned h_pixels,
                                                  input int unsigned v_lines);
    return (h_pixels * v_lines * 32'd2) / BYTES_PER_WORD;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs camera bytes into 128-bit words, byte 0 in the low lane, and
// presents each finished word with a one-cycle strobe.
module byte_packer
  import camera_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         byte_en_i,
  input  logic [7:0]   byte_i,
  output logic [127:0] p_data_o,
  output logic         data_valid_o,
  output logic [3:0]   byte_idx_o,
  output logic         word_done_o
);

  localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_WORD - 1);

  logic [127:0] shadow_q, shadow_d;
  logic [127:0] p_data_q, p_data_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d;

  // Next-state: fill the shadow lane, publish the word on the last byte
  always_comb begin
    shadow_d    = shadow_q;
    p_data_d    = p_data_q;
    idx_d       = idx_q;
    valid_d     = 1'b0;
    word_done_o = 1'b0;
    if (clear_i) begin
      idx_d = 4'd0;
    end else if (byte_en_i) begin
      shadow_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = idx_q + 4'd1;
      if (idx_q == LAST_IDX) begin
        p_data_d    = {byte_i, shadow_q[119:0]};
        valid_d     = 1'b1;
        word_done_o = 1'b1;
      end else begin
        p_data_d = p_data_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Packer state registers; p_data holds between strobes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= 128'd0;
      p_data_q <= 128'd0;
      idx_q    <= 4'd0;
      valid_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      p_data_q <= p_data_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
    end
  end

  assign p_data_o     = p_data_q;
  assign data_valid_o = valid_q;
  assign byte_idx_o   = idx_q;

endmodule

// File: rtl/camera_capture.sv
// Pixel-clock front end: registers the DVP bus, frames captures between
// vsync pulses, validates geometry and rotates through SDRAM frame slots.
module camera_capture
  import camera_pkg::*;
#(
  parameter int unsigned H_PIXELS  = 640,
  parameter int unsigned V_LINES   = 480,
  parameter int unsigned NUM_SLOTS = SLOT_COUNT,
  parameter int unsigned DONE_LEN  = 8
) (
  input  logic         p_clk,
  input  logic         rst,
  input  logic         cam_vsync,
  input  logic         cam_href,
  input  logic [7:0]   cam_data,
  input  logic         capture_en,
  output logic [127:0] p_data,
  output logic         data_valid,
  output logic         frame_done,
  output logic [2:0]   last_frame,
  output logic         frame_err
);

  localparam logic [31:0] WORDS      = 32'(words_per_frame(H_PIXELS, V_LINES));
  localparam logic [31:0] LINE_BYTES = 32'(2 * H_PIXELS);
  localparam logic [31:0] LINES      = 32'(V_LINES);
  localparam logic [31:0] DONE_LAST  = 32'(DONE_LEN - 1);
  localparam logic [2:0]  SLOT_LAST  = 3'(NUM_SLOTS - 1);

  logic       vsync_q, vsync_prev_q, href_q, href_prev_q;
  logic [7:0] data_q;

  cap_state_e  state_q;
  logic [31:0] word_cnt_q, word_cnt_d;
  logic [31:0] line_cnt_q, line_cnt_d;
  logic [31:0] line_byte_cnt_q, line_byte_cnt_d;
  logic [31:0] done_cnt_q;
  logic        err_q, err_d;
  logic        frame_done_q, frame_err_q;
  logic [2:0]  last_frame_q;

  logic       active_s, vs_rise_s, vs_fall_s, line_end_s, overflow_s;
  logic       in_byte_s, byte_en_s, word_done_s, residual_s, good_s, start_s;
  logic [3:0] byte_idx_s;

  // Single input register stage plus previous-value copies for edge detect
  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_q       <= 1'b0;
      href_prev_q  <= 1'b0;
      data_q       <= 8'd0;
    end else begin
      vsync_q      <= cam_vsync;
      vsync_prev_q <= vsync_q;
      href_q       <= cam_href;
      href_prev_q  <= href_q;
      data_q       <= cam_data;
    end
  end

  // Frame bookkeeping: next counter values include this cycle's events so a
  // word finishing on the vsync edge is counted before the frame is judged
  always_comb begin
    active_s   = (state_q == ACTIVE);
    vs_rise_s  = vsync_q & ~vsync_prev_q;
    vs_fall_s  = ~vsync_q & vsync_prev_q;
    line_end_s = active_s & href_prev_q & ~href_q;
    overflow_s = (word_cnt_q >= WORDS);
    in_byte_s  = active_s & href_q;
    byte_en_s  = in_byte_s & ~overflow_s;
    start_s    = (state_q == WAIT_FALL) & vs_fall_s & capture_en;

    word_cnt_d = word_cnt_q + {31'd0, word_done_s};
    line_cnt_d = line_cnt_q + {31'd0, line_end_s};
    if (line_end_s) begin
      line_byte_cnt_d = 32'd0;
    end else if (in_byte_s) begin
      line_byte_cnt_d = line_byte_cnt_q + 32'd1;
    end else begin
      line_byte_cnt_d = line_byte_cnt_q;
    end
    err_d = err_q
          | (in_byte_s & overflow_s)
          | (line_end_s & (line_byte_cnt_q != LINE_BYTES));
    residual_s = ((byte_idx_s + {3'b000, byte_en_s}) != 4'd0);
    good_s = ~err_d & ~residual_s & (line_cnt_d == LINES) & (word_cnt_d == WORDS);
  end

  byte_packer u_packer (
    .clk_i        (p_clk),
    .rst_i        (rst),
    .clear_i      (start_s),
    .byte_en_i    (byte_en_s),
    .byte_i       (data_q),
    .p_data_o     (p_data),
    .data_valid_o (data_valid),
    .byte_idx_o   (byte_idx_s),
    .word_done_o  (word_done_s)
  );

  // Framing FSM with counters, slot rotation and registered status outputs
  always_ff @(posedge p_clk or posedge rst) begin
    if (rst) begin
      state_q         <= WAIT_VS;
      word_cnt_q      <= 32'd0;
      line_cnt_q      <= 32'd0;
      line_byte_cnt_q <= 32'd0;
      done_cnt_q      <= 32'd0;
      err_q           <= 1'b0;
      frame_done_q    <= 1'b0;
      frame_err_q     <= 1'b0;
      last_frame_q    <= 3'd0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        WAIT_VS: begin
          if (vsync_q) begin
            state_q <= WAIT_FALL;
          end
        end
        WAIT_FALL: begin
          if (vs_fall_s) begin
            if (capture_en) begin
              state_q         <= ACTIVE;
              word_cnt_q      <= 32'd0;
              line_cnt_q      <= 32'd0;
              line_byte_cnt_q <= 32'd0;
              err_q           <= 1'b0;
            end else begin
              state_q <= WAIT_VS;
            end
          end
        end
        ACTIVE: begin
          word_cnt_q      <= word_cnt_d;
          line_cnt_q      <= line_cnt_d;
          line_byte_cnt_q <= line_byte_cnt_d;
          err_q           <= err_d;
          if (vs_rise_s) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            done_cnt_q   <= 32'd0;
            if (good_s) begin
              last_frame_q <= (last_frame_q == SLOT_LAST) ? 3'd0 : last_frame_q + 3'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (done_cnt_q == DONE_LAST) begin
            state_q      <= WAIT_FALL;
            frame_done_q <= 1'b0;
          end else begin
            done_cnt_q <= done_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q      <= WAIT_VS;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign last_frame = last_frame_q;

endmodule

// File: doc/camera_capture.md
# camera_capture

Pixel-side front end of the camera path, in the `p_clk` (24 MHz camera pixel clock) domain. It samples the 8-bit DVP camera bus (`cam_vsync`, `cam_href`, `cam_data`) and packs RGB565 bytes into 128-bit words. Each word is presented on `p_data` with a one-cycle `data_valid` strobe for the downstream clock-crossing FIFO/store stage. It tracks which of the six frame slots in SDRAM receives the next frame, and reports completion with `frame_done` and `last_frame`. Malformed frames are flagged, and the slot is reused.

## Interface
Parameters:
- `H_PIXELS`, 640, active pixels per line
- `V_LINES`, 480, active lines per frame
- `NUM_SLOTS`, 6, number of SDRAM frame slots; `last_frame` wraps at this value
- `DONE_LEN`, 8, `frame_done` high time in `p_clk` cycles; must cover ≥2 fast-clock samples

Ports:
- `p_clk`  in  1  camera pixel clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cam_vsync`  in  1  camera vertical sync, high between frames
- `cam_href`  in  1  camera line valid
- `cam_data`  in  8  camera byte, sampled when `cam_href`=1
- `capture_en`  in  1  allow starting a new frame
- `p_data`  out  128  packed word
- `data_valid`  out  1  one-cycle strobe, `p_data` valid
- `frame_done`  out  1  end-of-frame level, `DONE_LEN` cycles
- `last_frame`  out  3  slot index the next frame is written to
- `frame_err`  out  1  one-cycle pulse, the frame just ended was malformed

## Operation
- **Reset values:** `p_data`=0, `data_valid`=0, `frame_done`=0, `last_frame`=0, `frame_err`=0. State is `WAIT_VS`, and all counters are 0.
- **Input registers:** `cam_*` are registered once, giving one-cycle input latency. A `vsync` edge is detected on the registered copy against its previous value.
- **WAIT_VS:** waits for registered `vsync`=1.
  - → `WAIT_FALL`.
  - A partial frame that is in progress at reset is discarded.
- **WAIT_FALL:** on a `vsync` falling edge:
  - If `capture_en`=1 → `ACTIVE`, and clear the byte, line and word counters and the error flag.
  - If `capture_en`=0 → `WAIT_VS`.
- **ACTIVE:** packs bytes while `href`=1.
  - Byte k of a word (k=0..15) is placed in `p_data[8k+7:8k]`. Byte 0 is the first byte received.
  - Bytes are assembled in a shadow register. `p_data` is updated only on the strobe and holds until the next strobe.
  - On the 16th byte, `data_valid`=1 for exactly one cycle and the word counter increments.
  - **Line check:** on each `href` falling edge, the line byte count must equal 2·`H_PIXELS`. Otherwise the sticky error flag is set. The line counter increments.
  - **Overflow:** once the word count reaches `H_PIXELS`·`V_LINES`·2/16 (38400 at defaults), further bytes produce no `data_valid` and set the error flag. This prevents writes into the next slot.
  - **Frame end:** on a `vsync` rising edge → `DONE`. The frame is good if the error flag is clear, the line count equals `V_LINES`, and the word count equals the expected value.
- **DONE entry:**
  - Good frame: `last_frame` ← (`last_frame`+1) mod `NUM_SLOTS`.
  - Bad frame: `last_frame` is unchanged (the slot is overwritten next time) and `frame_err` pulses.
  - `frame_done`=1 for `DONE_LEN` cycles, with `last_frame` stable throughout.
- **DONE exit:** → `WAIT_FALL`. Bytes arriving in `DONE` are ignored.
- **Residual bytes:** a partial word at frame end is dropped and counts as an error (byte count not a multiple of 16).
- **`capture_en` deasserted mid-frame:** the current frame completes normally.

## Timing
- **Data latency:** `data_valid` rises 2 cycles after the `p_clk` edge that presents the 16th byte on `cam_data`: one cycle input register, one cycle pack.
- **Strobe spacing:** minimum 16 cycles between `data_valid` strobes. `data_valid` is never high on two consecutive cycles, so the downstream falling-edge detector sees each strobe.
- **`frame_done` rise:** rises 2 cycles after `cam_vsync` rises, the same cycle `last_frame` updates.
- **Simultaneous events:** if `vsync` rises on the same registered cycle as a 16th byte, the word is emitted first, then the frame is closed.
- **Reset:** asserting `rst` at any time clears all outputs asynchronously. Operation resumes at `WAIT_VS`.

## Structure
- Package `camera_pkg`:
  - state enum (`WAIT_VS`, `WAIT_FALL`, `ACTIVE`, `DONE`)
  - `WORDS_PER_FRAME` function of the parameters
  - slot count constant
- Sub-module `byte_packer` (shadow register, byte index 0..15, strobe generation).
- The framing FSM and counters stay in `camera_capture`.

## Test plan
- **Minimal frame:** `H_PIXELS`=8, `V_LINES`=2, bytes 0x00..0x1F → two strobes; `p_data`=0x0F0E…00 then 0x1F1E…10; `frame_done` 8 cycles; `last_frame` 0→1.
- **Slot wrap:** six good frames → `last_frame` sequence 1,2,3,4,5,0; no `frame_err`.
- **Short line:** one line 15 bytes instead of 16 → `frame_err` pulse at frame end; `last_frame` unchanged; `frame_done` still asserted.
- **Extra line:** 3 lines with `V_LINES`=2 → no `data_valid` beyond word 2; `frame_err`=1.
- **Start mid-frame:** reset released with `vsync`=0 and `href` toggling → no `data_valid` until after the next full vsync pulse.
- **Mid-word reset / `capture_en`:** `rst` pulse mid-word → all outputs 0 immediately; next good frame packs from byte 0. `capture_en`=0 at `vsync` fall → no capture that frame.
